// File: rtl/phy_pkg.sv
// Shared phy constants: comma byte, byte width, receive aligner state encoding.
package phy_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned CMA_CNT_W = 4;

  localparam logic [BYTE_W-1:0] COMMA = 8'hBC;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_COUNT  = 2'd1,
    ST_ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_rx_serial_paralelo_if.sv
// Serial input and byte-wide outputs of the receive serial-to-parallel stage.
interface phy_rx_serial_paralelo_if;
  import phy_pkg::*;

  logic              data_in;
  logic [BYTE_W-1:0] data_out;
  logic              valid_out;
  logic              byte_strobe;
  logic              active;

  modport slave  (input data_in, output data_out, valid_out, byte_strobe, active);
  modport master (output data_in, input data_out, valid_out, byte_strobe, active);

endinterface

// File: rtl/phy_rx_aligner.sv
// Bit-level comma hunt, comma run counting and byte alignment lock.
module phy_rx_aligner
  import phy_pkg::*;
#(
  parameter int unsigned SYNC_COMMAS = 4  // legal 1..15
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] nxt_c,
  output logic              byte_done_c,
  output logic              active
);

  rx_state_e              state_q, state_d;
  logic [BYTE_W-2:0]      sr_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CMA_CNT_W-1:0]   comma_cnt_q, comma_cnt_d;
  logic [CMA_CNT_W-1:0]   comma_inc_c;
  logic                   active_d;
  logic                   is_comma_c;
  logic                   last_bit_c;

  // Only the low seven history bits are needed to form the completing byte.
  assign nxt_c       = {sr_q, data_in};
  assign is_comma_c  = (nxt_c == COMMA);
  assign last_bit_c  = (bit_cnt_q == BIT_CNT_W'(7));
  assign comma_inc_c = comma_cnt_q + CMA_CNT_W'(1);
  assign byte_done_c = (state_q == ST_ACTIVE) && last_bit_c;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SEARCH;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      active      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= nxt_c[BYTE_W-2:0];
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      active      <= active_d;
    end
  end

  // Next state: SEARCH hunts every bit, COUNT/ACTIVE only look at aligned bytes.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + BIT_CNT_W'(1);
    comma_cnt_d = comma_cnt_q;
    active_d    = active;
    case (state_q)
      ST_SEARCH: begin
        bit_cnt_d = '0;
        if (is_comma_c) begin
          comma_cnt_d = CMA_CNT_W'(1);
          if (SYNC_COMMAS == 1) begin
            state_d  = ST_ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ST_COUNT;
          end
        end
      end
      ST_COUNT: begin
        if (last_bit_c) begin
          if (is_comma_c) begin
            comma_cnt_d = comma_inc_c;
            if (comma_inc_c == CMA_CNT_W'(SYNC_COMMAS)) begin
              state_d  = ST_ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            state_d     = ST_SEARCH;
            comma_cnt_d = '0;
          end
        end
      end
      ST_ACTIVE: begin
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

endmodule

// File: rtl/phy_rx_serial_paralelo.sv
// Receive serial-to-parallel converter: aligner plus registered byte outputs.
module phy_rx_serial_paralelo
  import phy_pkg::*;
#(
  parameter int unsigned SYNC_COMMAS = 4
) (
  input logic                      clk_32f,
  input logic                      reset,
  phy_rx_serial_paralelo_if.slave  rx
);

  logic [BYTE_W-1:0] nxt_c;
  logic              byte_done_c;
  logic              active;
  logic [BYTE_W-1:0] data_q;
  logic              valid_q;
  logic              strobe_q;

  phy_rx_aligner #(
    .SYNC_COMMAS (SYNC_COMMAS)
  ) u_aligner (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (rx.data_in),
    .nxt_c       (nxt_c),
    .byte_done_c (byte_done_c),
    .active      (active)
  );

  // Commas are idle: they strobe but never overwrite the held data byte.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= byte_done_c;
      if (byte_done_c) begin
        if (nxt_c != COMMA) begin
          data_q  <= nxt_c;
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign rx.data_out    = data_q;
  assign rx.valid_out   = valid_q;
  assign rx.byte_strobe = strobe_q;
  assign rx.active      = active;

endmodule

// File: tb/tb_phy_rx_serial_paralelo.sv
// Directed bench for phy_rx_serial_paralelo with a byte scoreboard on the main instance.
module tb_phy_rx_serial_paralelo;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } exp_t;

  logic clk_32f = 1'b0;
  logic reset   = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc         = 0;
  int   last_strobe = 0;
  bit   sel_b       = 1'b0;
  exp_t sbq[$];

  phy_rx_serial_paralelo_if a_if ();
  phy_rx_serial_paralelo_if b_if ();

  phy_rx_serial_paralelo #(.SYNC_COMMAS(4)) dut_a (
    .clk_32f (clk_32f),
    .reset   (reset),
    .rx      (a_if.slave)
  );

  phy_rx_serial_paralelo #(.SYNC_COMMAS(1)) dut_b (
    .clk_32f (clk_32f),
    .reset   (reset),
    .rx      (b_if.slave)
  );

  always #5 clk_32f = ~clk_32f;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit, advance to the next falling edge, then score any completed byte.
  task automatic tick(input logic b);
    exp_t e;
    a_if.data_in = sel_b ? 1'b0 : b;
    b_if.data_in = sel_b ? b : 1'b0;
    @(negedge clk_32f);
    cyc++;
    if (a_if.byte_strobe === 1'b1) begin
      if (last_strobe > 0) chk("strobe_period", 8'(cyc - last_strobe), 8'd8);
      last_strobe = cyc;
      if (sbq.size() == 0) begin
        chk("unexpected_strobe", 8'(sbq.size()), 8'd1);
      end else begin
        e = sbq.pop_front();
        chk("sb_valid", 8'(a_if.valid_out), 8'(e.valid));
        chk("sb_data", a_if.data_out, e.data);
      end
    end
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) tick(v[i]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 8);
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b0;
    last_strobe = 0;
    for (int i = 0; i < n; i++) tick(1'b0);
    reset = 1'b1;
  endtask

  initial begin
    a_if.data_in = 1'b0;
    b_if.data_in = 1'b0;
    @(negedge clk_32f);

    // Reset then idle, lock from a 3-bit offset
    hold_reset(3);
    chk("rst_data", a_if.data_out, 8'h00);
    chk("rst_valid", 8'(a_if.valid_out), 8'd0);
    chk("rst_strobe", 8'(a_if.byte_strobe), 8'd0);
    chk("rst_active", 8'(a_if.active), 8'd0);
    for (int i = 0; i < 3; i++) tick(1'b0);
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hBC);
      chk("lock_active_early", 8'(a_if.active), 8'd0);
    end
    send_bits(8'hBC, 7);
    chk("lock_active_pre_lsb", 8'(a_if.active), 8'd0);
    tick(1'b0);
    chk("lock_active", 8'(a_if.active), 8'd1);
    chk("lock_no_strobe", 8'(a_if.byte_strobe), 8'd0);
    chk("b_idle_active", 8'(b_if.active), 8'd0);

    // Data after lock
    sbq.push_back('{1'b1, 8'hA5});
    send_byte(8'hA5);
    chk("a5_data", a_if.data_out, 8'hA5);
    chk("a5_valid", 8'(a_if.valid_out), 8'd1);
    sbq.push_back('{1'b1, 8'h3C});
    send_bits(8'h3C, 4);
    chk("mid_byte_valid", 8'(a_if.valid_out), 8'd1);
    chk("mid_byte_strobe", 8'(a_if.byte_strobe), 8'd0);
    send_bits(8'hC0, 4);
    sbq.push_back('{1'b0, 8'h3C});
    send_byte(8'hBC);
    chk("comma_valid", 8'(a_if.valid_out), 8'd0);
    chk("comma_data_hold", a_if.data_out, 8'h3C);

    // Straddled comma stays unaligned while active
    sbq.push_back('{1'b1, 8'h0B});
    send_byte(8'h0B);
    sbq.push_back('{1'b1, 8'hC0});
    send_byte(8'hC0);
    chk("straddle_data", a_if.data_out, 8'hC0);
    chk("straddle_active", 8'(a_if.active), 8'd1);

    // Reset mid-byte clears outputs asynchronously
    send_bits(8'h66, 3);
    reset = 1'b0;
    #1;
    chk("async_data", a_if.data_out, 8'h00);
    chk("async_valid", 8'(a_if.valid_out), 8'd0);
    chk("async_active", 8'(a_if.active), 8'd0);
    chk("sb_drained", 8'(sbq.size()), 8'd0);
    hold_reset(2);

    // Broken comma run, then relock needs a full run of four
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h12);
    chk("broken_active", 8'(a_if.active), 8'd0);
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hBC);
      chk("relock_early", 8'(a_if.active), 8'd0);
    end
    send_byte(8'hBC);
    chk("relock_active", 8'(a_if.active), 8'd1);
    sbq.push_back('{1'b1, 8'h5A});
    send_byte(8'h5A);
    chk("relock_data", a_if.data_out, 8'h5A);

    // SYNC_COMMAS=1 instance
    hold_reset(2);
    sel_b = 1'b1;
    send_bits(8'hBC, 7);
    chk("s1_pre_lsb", 8'(b_if.active), 8'd0);
    tick(1'b0);
    chk("s1_active", 8'(b_if.active), 8'd1);
    chk("s1_no_strobe", 8'(b_if.byte_strobe), 8'd0);
    send_byte(8'h55);
    chk("s1_strobe", 8'(b_if.byte_strobe), 8'd1);
    chk("s1_valid", 8'(b_if.valid_out), 8'd1);
    chk("s1_data", b_if.data_out, 8'h55);
    chk("s1_a_idle", 8'(a_if.active), 8'd0);

    chk("sb_empty", 8'(sbq.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
